// File: rtl/pwm_defs.sv
// Shared definitions for the PWM generator and capture blocks:
// capture FSM state encoding and default sizing constants.
package pwm_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } pwm_state_t;

    localparam int PWM_CNT_W       = 16;
    localparam int PWM_TIMEOUT     = 65535;
    localparam int PWM_SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with registered rise/fall
// pulses, masked during a short warm-up so a level present at reset is not an edge.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int WARM_W   = $clog2(WARM_MAX + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   warm_done;

    assign s         = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_W'(WARM_MAX));
    assign level     = s_d;
    assign ready     = warm_done;

    // Edge pulses are registered alongside s_d, so 'level' matches the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_d      <= 1'b0;
            warm_cnt <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            s_d    <= s;
            if (!warm_done) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            rise <= warm_done & s & ~s_d;
            fall <= warm_done & ~s & s_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input in clk cycles, publishing each
// rise-to-rise measurement with a one-cycle strobe and flagging a stuck input.
module pwm_capture
    import pwm_defs::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int TIMEOUT     = PWM_TIMEOUT,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic             level;
    logic             rise;
    logic             fall;
    logic             ready;

    pwm_state_t       state;
    pwm_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_q;
    logic             timed_out;
    logic             publish;
    logic             latch_high;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .ready    (ready)
    );

    assign cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    assign timed_out   = (cnt == CNT_MAX);
    assign stuck       = (state == ST_STUCK);
    assign stuck_level = stuck & level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A rise always takes priority over timeout; the count restarts at 1 so
    // the value seen on the next rise equals the full period.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        publish    = 1'b0;
        latch_high = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    next_state = ST_HIGH;
                    cnt_next   = CNT_W'(1);
                end else if (timed_out) begin
                    next_state = ST_STUCK;
                end else if (ready) begin
                    cnt_next = cnt_inc;
                end
            end
            ST_HIGH: begin
                if (rise) begin
                    cnt_next = CNT_W'(1);
                end else if (timed_out) begin
                    next_state = ST_STUCK;
                end else begin
                    cnt_next = cnt_inc;
                    if (fall) begin
                        next_state = ST_LOW;
                        latch_high = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    next_state = ST_HIGH;
                    cnt_next   = CNT_W'(1);
                    publish    = 1'b1;
                end else if (timed_out) begin
                    next_state = ST_STUCK;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_STUCK: begin
                if (rise) begin
                    next_state = ST_HIGH;
                    cnt_next   = CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            high_q     <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            meas_valid <= publish;
            if (latch_high) begin
                high_q <= cnt;
            end
            if (publish) begin
                period_out <= cnt;
                high_out   <= high_q;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture: each generated rise queues the
// expected measurement of the period it closes; a monitor checks every strobe.
module tb_pwm_capture;

    localparam int CNT_W       = 12;
    localparam int TIMEOUT     = 1000;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    typedef struct {
        int period;
        int high;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    exp_t got;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   prev_h = 0;
    int   prev_l = 0;
    bit   prev_ok = 1'b0;
    int   last_period = 0;
    int   last_high = 0;
    int   mark = 0;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A rise closes the previous pulse: its measurement is H+L and H.
    task automatic rise_edge(input int h, input int l);
        pwm_in = 1'b1;
        if (prev_ok) begin
            pend.period = prev_h + prev_l;
            pend.high   = prev_h;
            pend.due    = cyc + LAT;
            sb.push_back(pend);
            last_period = pend.period;
            last_high   = pend.high;
        end
        prev_h  = h;
        prev_l  = l;
        prev_ok = (h + l <= TIMEOUT);
    endtask

    task automatic apply_stimulus(input int h, input int l);
        rise_edge(h, l);
        tick(h);
        pwm_in = 1'b0;
        tick(l);
    endtask

    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got period %0d high %0d expected no strobe (cycle %0d)",
                         period_out, high_out, cyc);
            end else begin
                got = sb.pop_front();
                check_output("period_out", int'(period_out), got.period);
                check_output("high_out", int'(high_out), got.high);
                check_output("valid_cycle", cyc, got.due);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        check_output("reset_period", int'(period_out), 0);
        check_output("reset_high", int'(high_out), 0);
        check_output("reset_valid", int'(meas_valid), 0);
        check_output("reset_stuck", int'(stuck), 0);
        check_output("reset_stuck_level", int'(stuck_level), 0);
        rst_n = 1'b1;
        tick(10);

        repeat (5) apply_stimulus(60, 140);
        repeat (20) apply_stimulus(1, 1);
        for (int i = 0; i < 25; i++) begin
            apply_stimulus(int'($urandom_range(1, 300)), int'($urandom_range(1, 300)));
        end
        apply_stimulus(400, TIMEOUT - 400);
        repeat (3) apply_stimulus(60, 140);
        repeat (3) apply_stimulus(140, 60);

        // Input goes quiet low after one last rise.
        mark = cyc;
        apply_stimulus(50, 0);
        prev_ok = 1'b0;
        tick(mark + TIMEOUT - cyc);
        check_output("stuck_low_early", int'(stuck), 0);
        tick(LAT + 2);
        check_output("stuck_low", int'(stuck), 1);
        check_output("stuck_low_level", int'(stuck_level), 0);
        check_output("stuck_hold_period", int'(period_out), last_period);
        check_output("stuck_hold_high", int'(high_out), last_high);
        repeat (3) apply_stimulus(100, 300);
        check_output("recover_low_stuck", int'(stuck), 0);

        // Reset in the middle of a high phase.
        rise_edge(999, 0);
        tick(20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_period", int'(period_out), 0);
        check_output("midrst_high", int'(high_out), 0);
        check_output("midrst_valid", int'(meas_valid), 0);
        check_output("midrst_stuck", int'(stuck), 0);
        tick(3);
        rst_n   = 1'b1;
        prev_ok = 1'b0;
        tick(30);
        pwm_in = 1'b0;
        tick(50);
        repeat (3) apply_stimulus(70, 130);

        // Input held high through and after reset.
        pwm_in = 1'b1;
        rst_n  = 1'b0;
        tick(3);
        rst_n   = 1'b1;
        prev_ok = 1'b0;
        tick(TIMEOUT);
        check_output("stuck_high_early", int'(stuck), 0);
        tick(SYNC_STAGES + 6);
        check_output("stuck_high", int'(stuck), 1);
        check_output("stuck_high_level", int'(stuck_level), 1);
        pwm_in = 1'b0;
        tick(300);
        check_output("stuck_fall_ignored", int'(stuck), 1);
        check_output("stuck_level_follows", int'(stuck_level), 0);
        rise_edge(100, 300);
        tick(LAT + 2);
        check_output("stuck_cleared", int'(stuck), 0);
        tick(100 - LAT - 2);
        pwm_in = 1'b0;
        tick(300);
        repeat (2) apply_stimulus(100, 300);

        pwm_in = 1'b0;
        tick(20);
        check_output("pending_strobes", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side companion to the PWM generator. Samples an external or looped-back PWM signal and measures its period and high time in clk cycles. Publishes each complete rise-to-rise measurement with a one-cycle valid strobe. Flags a stuck input (0% or 100% duty, or no signal). Used for loopback self-test of the fade controller and for reading external PWM sources such as fan tach or servo signals.

Parameters:
CNT_W, 16, width of period/high counters and outputs
TIMEOUT, 65535, cycles without a rising edge before stuck is declared; must be ≤ 2^CNT_W-1
SYNC_STAGES, 2, synchronizer flops on pwm_in (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pwm_in  in  1  asynchronous PWM input
period_out  out  CNT_W  last measured period, in cycles
high_out  out  CNT_W  last measured high time, in cycles
meas_valid  out  1  one-cycle pulse when period_out/high_out update
stuck  out  1  input has had no rising edge for TIMEOUT cycles
stuck_level  out  1  synced level of pwm_in when stuck asserted

Behaviour:
- Reset (async, active-low) clears everything to 0: period_out, high_out, meas_valid, stuck, stuck_level, counters and synchronizer flops. FSM goes to IDLE.
- Synchronizer: pwm_in passes through SYNC_STAGES flops to give s. Edge detector compares s with a delayed copy s_d.
- Warm-up: for the first SYNC_STAGES+1 cycles after reset release, edges are ignored while s_d tracks s. This stops a high input at reset from producing a false rise.
- FSM states: IDLE, HIGH, LOW, STUCK.
  - IDLE: waits for a rise, then goes to HIGH and starts the count. Any partial period before the first rise is discarded.
  - HIGH: on a fall, latches the high count and goes to LOW.
  - LOW: on a rise, publishes the measurement and goes to HIGH, restarting the count in the same cycle.
  - Any state except STUCK: if the count since the last rise (or since warm-up end, in IDLE) reaches TIMEOUT, go to STUCK.
  - STUCK: stuck=1 and stuck_level=s. On a rise, clear stuck and go to HIGH as a fresh start with no publish.
- Measurement definition: if the synced signal is high for H cycles and low for L cycles, the results are period_out=H+L and high_out=H exactly.
- Minimum measurable period is H=1, L=1, giving period_out=2 and high_out=1.
- Output timing: period_out, high_out and meas_valid are registered. They update together in the cycle after the rise is detected.
- meas_valid is high for exactly 1 cycle per completed period.
- Outputs hold their last values between updates, including while stuck.
- Counters saturate at TIMEOUT and never wrap. The transition to STUCK happens on the count that reaches TIMEOUT.
- A fall in IDLE or STUCK is ignored.
- A rise in the same cycle as TIMEOUT is reached: the rise wins, the measurement is published if in LOW, and there is no stuck.
- No publish ever occurs from IDLE, HIGH or STUCK.
- Reset mid-measurement discards partial counts. The first valid after reset requires a full rise-to-rise interval after warm-up.
- Total input-to-meas_valid latency from the pwm_in rising transition is SYNC_STAGES+2 cycles.

Decomposition:
- Shared package/include pwm_defs holds the FSM state encodings (IDLE, HIGH, LOW, STUCK, 2 bits) and the default CNT_W and TIMEOUT constants.
- The PWM generator and the capture block both use pwm_defs.
- One sub-module, pwm_sync_edge: SYNC_STAGES synchronizer plus warm-up counter and rise/fall pulse outputs. It is reusable for other async inputs.

Test Plan:
1. Steady PWM, H=6000, L=14000 → first meas_valid after one full period following the first rise. Then a pulse every 20000 cycles with period_out=20000 and high_out=6000.
2. Minimum-width toggle, H=1, L=1 → meas_valid every 2 cycles with period_out=2 and high_out=1, with no missed strobes.
3. TIMEOUT=1000, pwm_in held 1 through and after reset → no meas_valid. stuck=1 and stuck_level=1 about 1000 cycles after warm-up. Starting PWM (H=100, L=300) → stuck clears on the first rise, and period_out=400, high_out=100 after one full period.
4. After test 1 measurements, force pwm_in=0 → stuck=1 and stuck_level=0 after TIMEOUT cycles from the last rise. period_out=20000 and high_out=6000 are held.
5. Assert rst_n low mid-HIGH phase → all outputs 0 immediately. After release, the first meas_valid comes only after a complete rise-to-rise interval.
6. Duty step, H=6000 to H=14000 at a period boundary with period 20000 → high_out goes 6000 then 14000 with no intermediate value. period_out stays 20000.
